// File: rtl/stall_mem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// state encoding and latency counter width.
package stall_mem_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StBusy = ST_BUSY,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage array: synchronous write, registered read port.
// The read register clears on reset; the array contents do not.
module mem_word_array #(
  parameter int unsigned DepthLog2 = 8,
  parameter int unsigned Width     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic [DepthLog2-1:0] idx_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stall_mem_resp.sv
// Multi-cycle data-memory responder: accepts one request, holds it for LATENCY
// cycles while stalling the memory stage, then completes with a done pulse.
module stall_mem_resp
  import stall_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [15:0]           data_q;
  logic                  is_wr_q;
  logic                  done_q;
  logic                  err_q, err_d;

  logic                  req, illegal, accept, complete;
  logic                  mem_we, mem_re, comp_wr;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [15:0]           mem_wdata;
  logic                  unused_addr;

  assign unused_addr = ^addr[15:DEPTH_LOG2+1];

  assign req     = rd | wr;
  assign illegal = (rd & wr) | addr[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (req) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            accept = 1'b1;
            cnt_d  = CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_d  = StDone;
              complete = 1'b1;
            end else begin
              state_d = StBusy;
            end
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = StDone;
          complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      is_wr_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == StDone);
      err_q   <= err_d;
      if (accept) begin
        idx_q   <= addr[DEPTH_LOG2:1];
        data_q  <= data_in;
        is_wr_q <= wr;
      end
    end
  end

  // With LATENCY=1 completion coincides with acceptance, so use the live request.
  always_comb begin
    if (state_q == StBusy) begin
      mem_idx   = idx_q;
      mem_wdata = data_q;
      comp_wr   = is_wr_q;
    end else begin
      mem_idx   = addr[DEPTH_LOG2:1];
      mem_wdata = data_in;
      comp_wr   = wr;
    end
  end

  // Reset aborts an in-flight completion, so a pending write never lands.
  assign mem_we = complete & comp_wr & ~rst;
  assign mem_re = complete & ~comp_wr & ~rst;

  mem_word_array #(
    .DepthLog2 (DEPTH_LOG2),
    .Width     (16)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (mem_idx),
    .wdata_i (mem_wdata),
    .rdata_o (data_out)
  );

  assign done  = done_q;
  assign err   = err_q;
  assign stall = (state_q == StBusy);

endmodule

// File: tb/tb_stall_mem_resp.sv
// Bench for stall_mem_resp: one instance at LATENCY=4 and one at LATENCY=1,
// checked against a word-array model and cycle-count expectations.
module tb_stall_mem_resp;

  logic        clk = 1'b0;
  logic        rst, rd, wr, sel;
  logic [15:0] addr, din;

  logic [15:0] a_dout, b_dout;
  logic        a_done, a_stall, a_err, b_done, b_stall, b_err;
  logic [15:0] dout;
  logic        done, stall, err;

  int checks   = 0;
  int failures = 0;

  logic [15:0] model [2][256];
  bit          known [2][256];

  always #5 clk = ~clk;

  stall_mem_resp #(.DEPTH_LOG2(8), .LATENCY(4)) dut_a (
    .clk (clk), .rst (rst), .addr (addr), .data_in (din),
    .rd (rd & ~sel), .wr (wr & ~sel),
    .data_out (a_dout), .done (a_done), .stall (a_stall), .err (a_err)
  );

  stall_mem_resp #(.DEPTH_LOG2(8), .LATENCY(1)) dut_b (
    .clk (clk), .rst (rst), .addr (addr), .data_in (din),
    .rd (rd & sel), .wr (wr & sel),
    .data_out (b_dout), .done (b_done), .stall (b_stall), .err (b_err)
  );

  assign dout  = sel ? b_dout : a_dout;
  assign done  = sel ? b_done : a_done;
  assign stall = sel ? b_stall : a_stall;
  assign err   = sel ? b_err : a_err;

  // Called at a falling edge; drives a request and follows it to its done cycle.
  task automatic txn(input bit is_wr, input logic [15:0] ad, input logic [15:0] d,
                     input bit hold);
    int lat;
    int w;
    lat = sel ? 1 : 4;
    w   = (int'(ad) / 2) % 256;
    rd = ~is_wr; wr = is_wr; addr = ad; din = d;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      checks++;
      if (stall !== (n < lat) || done !== (n == lat) || err !== 1'b0) begin
        failures++;
        $display("FAIL txn_timing sel=%0d addr=%h cycle=%0d: stall=%b done=%b err=%b want stall=%b done=%b err=0",
                 sel, ad, n, stall, done, err, (n < lat), (n == lat));
      end
    end
    if (is_wr) begin
      model[sel][w] = d;
      known[sel][w] = 1'b1;
    end else if (known[sel][w]) begin
      checks++;
      if (dout !== model[sel][w]) begin
        failures++;
        $display("FAIL read_data sel=%0d addr=%h: got %h want %h", sel, ad, dout, model[sel][w]);
      end
    end
    if (!hold) begin
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  // Called at a falling edge; presents an illegal request for one edge.
  task automatic bad_req(input bit both, input logic [15:0] ad);
    rd = 1'b1; wr = both; addr = ad; din = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pulse addr=%h: err=%b done=%b stall=%b want 1 0 0", ad, err, done, stall);
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL illegal_after addr=%h: err=%b done=%b stall=%b want 0 0 0", ad, err, done, stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rd = 1'b0; wr = 1'b0; sel = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_done, a_stall, a_err, a_dout} !== 19'd0 || {b_done, b_stall, b_err, b_dout} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state: a=%b%b%b/%h b=%b%b%b/%h want all zero",
               a_done, a_stall, a_err, a_dout, b_done, b_stall, b_err, b_dout);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    sel = 1'b0;
    txn(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    @(negedge clk);
    txn(1'b0, 16'h0010, 16'h0000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dout !== 16'hBEEF || done !== 1'b0) begin
        failures++;
        $display("FAIL data_out_hold: got %h done=%b want BEEF done=0", dout, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    txn(1'b1, 16'h0020, 16'h1234, 1'b1);
    txn(1'b1, 16'h0022, 16'h5678, 1'b0);
    @(negedge clk);
    txn(1'b0, 16'h0020, 16'h0000, 1'b1);
    txn(1'b0, 16'h0022, 16'h0000, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_illegal();
    sel = 1'b0;
    txn(1'b1, 16'h0004, 16'h4444, 1'b0);
    @(negedge clk);
    bad_req(1'b1, 16'h0004);
    bad_req(1'b0, 16'h0005);
    txn(1'b0, 16'h0004, 16'h0000, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_wrap_latency1();
    sel = 1'b1;
    txn(1'b1, 16'h0200, 16'hAAAA, 1'b0);
    @(negedge clk);
    txn(1'b0, 16'h0000, 16'h0000, 1'b1);
    txn(1'b1, 16'h0006, 16'h0666, 1'b1);
    txn(1'b0, 16'hF206, 16'h0000, 1'b0);
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    sel = 1'b0;
    txn(1'b1, 16'h0030, 16'h1111, 1'b0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 16'h0030; din = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      checks++;
      if (done !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL reset_abort: done=%b stall=%b want 0 0", done, stall);
      end
      @(negedge clk);
    end
    txn(1'b0, 16'h0030, 16'h0000, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_random();
    bit prev_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [15:0] ad;
      bit          hold;
      if (!prev_hold) @(negedge clk);
      sel  = 1'($urandom_range(0, 1));
      op   = $urandom_range(0, 9);
      ad   = 16'(($urandom_range(0, 127) << 9) | ($urandom_range(0, 15) << 1));
      hold = (op >= 2) && ($urandom_range(0, 2) == 0) && (i != 59);
      if (op < 2) begin
        if (op == 0) bad_req(1'b1, ad);
        else bad_req(1'b0, ad | 16'h0001);
      end else begin
        txn(op < 6, ad, 16'($urandom), hold);
      end
      prev_hold = hold;
    end
    rd = 1'b0; wr = 1'b0; sel = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_wrap_latency1();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
